spi_slave_rx: RTL and testbench

- SPI mode-0 slave that receives MSB-first N-bit frames from the team's SPI master: cs active-low, sclk idle low, mosi sampled on sclk rising edge.
- Runs on its own system clock, which oversamples the SPI pins through synchronizers.
- Presents each completed frame as a parallel word with a one-cycle valid strobe.
- Flags malformed frames and, optionally, shifts a reply word out on miso.

---
 rtl/spi_slave_rx.sv | 158 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 receive slave, oversampled on clk.
// Optional reply shifter on miso enabled by defining SPI_SLAVE_MISO_EN.
module spi_slave_rx #(
   parameter int N           = 16,
   parameter int DATA_WIDTH  = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sclk,
   input  logic         cs,
   input  logic         mosi,
   output logic         miso,
   input  logic [N-1:0] tx_data,
   output logic [N-1:0] rx_data,
   output logic         rx_valid,
   output logic         rx_err,
   output logic         busy
);

   localparam logic [DATA_WIDTH-1:0] N_CNT = DATA_WIDTH'(N);

   typedef enum logic [1:0] {
      S_LOCKOUT = 2'd0,
      S_IDLE    = 2'd1,
      S_RECV    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_hist_q;
   logic                   cs_hist_q;

   state_t                 state_q;
   logic [DATA_WIDTH-1:0]  count_q;
   logic [N-1:0]           shreg_q;
   logic                   overlong_q;
   logic [N-1:0]           rx_data_q;
   logic                   rx_valid_q;
   logic                   rx_err_q;
   logic                   busy_q;

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   logic sclk_rise;
   logic cs_rise;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign cs_rise   = cs_s & ~cs_hist_q;

   // cs synchronizer resets to "asserted" so the lockout state waits for a real deselect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         cs_hist_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_hist_q <= sclk_s;
         cs_hist_q   <= cs_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LOCKOUT;
         count_q    <= '0;
         shreg_q    <= '0;
         overlong_q <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         case (state_q)
            S_LOCKOUT: begin
               if (cs_s) state_q <= S_IDLE;
            end
            // Level test also catches a cs fall that landed during S_DONE.
            S_IDLE: begin
               if (!cs_s) begin
                  state_q    <= S_RECV;
                  count_q    <= '0;
                  shreg_q    <= '0;
                  overlong_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_RECV: begin
               if (sclk_rise) begin
                  if (count_q != N_CNT) begin
                     shreg_q <= {shreg_q[N-2:0], mosi_s};
                     count_q <= count_q + DATA_WIDTH'(1);
                  end else begin
                     overlong_q <= 1'b1;
                  end
               end
               if (cs_rise) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               if (count_q == N_CNT && !overlong_q) begin
                  rx_data_q  <= shreg_q;
                  rx_valid_q <= 1'b1;
               end else begin
                  rx_err_q <= 1'b1;
               end
            end
            default: state_q <= S_LOCKOUT;
         endcase
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;
   assign busy     = busy_q;

`ifdef SPI_SLAVE_MISO_EN
   logic [N-1:0] shadow_q;
   logic         sclk_fall;

   assign sclk_fall = ~sclk_s & sclk_hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (state_q == S_IDLE && !cs_s) begin
         shadow_q <= tx_data;
      end else if (state_q == S_RECV && sclk_fall) begin
         shadow_q <= {shadow_q[N-2:0], 1'b0};
      end
   end

   assign miso = (state_q == S_RECV && count_q != N_CNT) ? shadow_q[N-1] : 1'b0;
`else
   logic unused_tx;

   assign unused_tx = ^tx_data;
   assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - scoreboard bench for spi_slave_rx with random frames.
module tb_spi_slave_rx;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sclk;
   logic         cs;
   logic         mosi;
   logic         miso;
   logic [N-1:0] tx_data;
   logic [N-1:0] rx_data;
   logic         rx_valid;
   logic         rx_err;
   logic         busy;

   spi_slave_rx #(.N(N), .DATA_WIDTH(5), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .cs       (cs),
      .mosi     (mosi),
      .miso     (miso),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] last_good;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && (rx_valid || rx_err)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got valid=%0b err=%0b, expected none at %0t",
                     rx_valid, rx_err, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_kind", {30'd0, rx_valid, rx_err}, e.err ? 32'd1 : 32'd2);
            check("rx_data", {16'd0, rx_data}, {16'd0, e.data});
         end
      end
   end

   function automatic logic exp_miso(input logic [15:0] tx, input int bit_idx);
`ifdef SPI_SLAVE_MISO_EN
      if (bit_idx < 16) return tx[15 - bit_idx];
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic send_frame(input logic [15:0] word, input int nbits, input logic [15:0] tx,
                             input bit close, input int gap);
      int  k;
      bit  seen;
      tx_data = tx;
      cs      = 1'b0;
      clk_wait(6);
      if (close) check("busy_in_frame", {31'd0, busy}, 32'd1);
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 16) ? word[15 - i] : 1'($urandom);
         clk_wait(5);
         if (close) check("miso_bit", {31'd0, miso}, {31'd0, exp_miso(tx, i)});
         sclk = 1'b1;
         clk_wait(5);
         sclk = 1'b0;
      end
      clk_wait(5);
      if (!close) return;
      if (nbits == 16) begin
         exp_q.push_back('{err: 1'b0, data: word});
         last_good = word;
      end else begin
         exp_q.push_back('{err: 1'b1, data: last_good});
      end
      cs   = 1'b1;
      k    = 0;
      seen = 1'b0;
      while (k < 20 && !seen) begin
         @(posedge clk);
         #1;
         k++;
         if (rx_valid || rx_err) seen = 1'b1;
      end
      check("strobe_latency", k, 4);
      check("miso_after_cs", {31'd0, miso}, 32'd0);
      if (gap > 4) clk_wait(gap - 4);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      rst_n     = 1'b0;
      sclk      = 1'b0;
      cs        = 1'b0;
      mosi      = 1'b0;
      tx_data   = '0;
      last_good = 16'h0000;
      clk_wait(4);
      check("reset_rx_data", {16'd0, rx_data}, 32'd0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_err", {31'd0, rx_err}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_miso", {31'd0, miso}, 32'd0);
      rst_n = 1'b1;

      // Frame already in progress at reset release must be dropped.
      send_frame(16'($urandom), 16, 16'hFFFF, 1'b0, 0);
      check("lockout_busy", {31'd0, busy}, 32'd0);
      cs = 1'b1;
      clk_wait(8);
      check("lockout_no_busy", {31'd0, busy}, 32'd0);

      send_frame(16'hA5C3, 16, 16'h8001, 1'b1, 8);
      send_frame(16'h0001, 16, 16'h1234, 1'b1, 4);
      send_frame(16'hFFFF, 16, 16'hFFFF, 1'b1, 8);
      send_frame(16'h5A00, 9, 16'h00FF, 1'b1, 8);
      send_frame(16'h1357, 17, 16'hA5A5, 1'b1, 8);

      for (int i = 0; i < 8; i++) begin
         sclk = 1'b1;
         mosi = 1'($urandom);
         clk_wait(5);
         check("idle_sclk_busy", {31'd0, busy}, 32'd0);
         sclk = 1'b0;
         clk_wait(5);
      end

      for (int r = 0; r < 20; r++) begin
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 16;
         send_frame(16'($urandom), nb, 16'($urandom), 1'b1, int'($urandom_range(4, 10)));
      end

      clk_wait(10);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
